// File: rtl/div_iter_unit_pkg.sv
// Shared state codes and handshake constants for the iterative divider and the EX stage.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // EX drives and compares against these literally; keep the values fixed.
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_iter_unit_if.sv
// EX <-> divider handshake: operands and level start from EX, registered result and ready back.
interface div_iter_unit_if #(parameter int WIDTH = 32);

    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );

endinterface

// File: rtl/div_iter_unit_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor, keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // rem < divisor always holds, so the true difference fits in WIDTH bits and wraparound is harmless.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor});
        diff     = shifted[WIDTH-1:0] - divisor;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for EX div/divu; one quotient bit per clock, result held while start stays high.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_iter_unit_if.slave bus
);

    localparam int CntW = $clog2(WIDTH);

    div_state_t         state, next_state;
    logic               sgn_q, neg1_q, neg2_q;
    logic [WIDTH-1:0]   abs2_q;
    logic [WIDTH-1:0]   rem_q, quo_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               op1_neg, op2_neg, accept, divisor_zero, last_step;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   rem_nx, quo_nx, q_fix, r_fix;

    always_comb begin
        op1_neg      = bus.signed_div & bus.opdata1[WIDTH-1];
        op2_neg      = bus.signed_div & bus.opdata2[WIDTH-1];
        abs1         = op1_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
        abs2         = op2_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;
        accept       = (bus.start == DivStart) && !bus.annul;
        divisor_zero = (bus.opdata2 == '0);
        last_step    = (cnt_q == CntW'(WIDTH - 1));
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (abs2_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Sign fixup applies to the final step's output so the result registers on the same edge as ready.
    always_comb begin
        q_fix = (sgn_q && (neg1_q != neg2_q)) ? (~quo_nx + 1'b1) : quo_nx;
        r_fix = (sgn_q && neg1_q) ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DivFree;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DivFree:   if (accept) next_state = divisor_zero ? DivByZero : DivOn;
            DivByZero: next_state = DivEnd;
            DivOn:     if (bus.annul) next_state = DivFree;
                       else if (last_step) next_state = DivEnd;
            DivEnd:    if ((bus.start == DivStop) || bus.annul) next_state = DivFree;
            default:   next_state = DivFree;
        endcase
    end

    always_comb begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        case (state)
            DivByZero: ready_d = DivResultReady;
            DivOn: begin
                if (!bus.annul && last_step) begin
                    ready_d  = DivResultReady;
                    result_d = {r_fix, q_fix};
                end
            end
            DivEnd: begin
                if ((bus.start == DivStart) && !bus.annul) begin
                    ready_d  = DivResultReady;
                    result_d = result_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= DivResultNotReady;
            result_q <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            abs2_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            ready_q  <= ready_d;
            result_q <= result_d;
            if (state == DivFree && accept && !divisor_zero) begin
                sgn_q  <= bus.signed_div;
                neg1_q <= op1_neg;
                neg2_q <= op2_neg;
                abs2_q <= abs2;
                rem_q  <= '0;
                quo_q  <= abs1;
                cnt_q  <= '0;
            end else if (state == DivOn) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.result = result_q;

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
Iterative radix-2 restoring divider that serves the EX stage's div/divu handshake.
- EX holds start high with operands while ready is low, and stalls the pipeline meanwhile.
- The unit latches the operands, runs one quotient bit per clock, and returns {remainder, quotient} with ready high.
- EX then drops start; the unit returns to idle.
- Downstream, remainder goes to HI and quotient to LO.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
signed_div_i  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
opdata1_i  in  WIDTH  dividend; sampled with start.
opdata2_i  in  WIDTH  divisor; sampled with start.
start_i  in  1  request; level, held by EX until ready seen.
annul_i  in  1  abort current operation.
result_o  out  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient; registered.
ready_o  out  1  result valid; registered.

Behaviour:
- Reset: state=FREE, result_o=0, ready_o=0, cnt=0; operand and work registers cleared.
- Reset mid-operation aborts with no residual state.
- FSM states: FREE, BYZERO, ON, END; encodings are in the shared package.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Latch signed_div_i, the sign of each operand, and |op| (two's-complement negate when signed and the MSB is set; else raw). Work register {rem[W:0]=0, quo=|op1|}, cnt=0.
  - Otherwise stay in FREE.
- BYZERO: next edge -> END with result 0 (quotient 0, remainder 0).
- ON:
  - Each edge performs one step: shift {rem,quo} left 1, diff = rem - {0,|op2|}.
  - If diff >= 0: rem=diff, quo[0]=1.
  - cnt++; the step taken at cnt==W-1 is the last, then -> END.
  - annul_i=1 in ON -> FREE; no result, ready_o stays 0.
  - Operand input changes during ON are ignored.
- END:
  - ready_o=1.
  - Quotient is negated if signed and the signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - result_o holds stable while start_i=1.
  - start_i=0 or annul_i=1 -> FREE, with ready_o=0 and result_o=0 on that edge.
- Latency, counted from the edge sampling start in FREE:
  - Normal: ready_o is high after edge W+1, i.e. 33 edges for W=32.
  - Divide by zero: ready_o is high after edge 2.
- Signed overflow: 0x80000000 / -1 (signed) gives quotient 0x80000000, remainder 0. This is natural wrap; no trap.
- Back-to-back: a new start is accepted only from FREE, so start must be low for at least one edge between operations.
- ready_o is never high in FREE, BYZERO or ON.

Decomposition:
- Shared package / defines.vh: DivFree, DivByZero, DivOn, DivEnd state codes; DivStart/DivStop; DivResultReady/DivResultNotReady; ZeroWord.
- EX already references the handshake constants, so they must stay identical there.
- One natural combinational sub-module, div_step: input {rem,quo} and divisor, output the next {rem,quo}. This isolates the subtract-and-restore for unit testing.
- Sign handling and the FSM stay in the top module.

Test Plan:
1. Unsigned 100 / 7, start held until ready -> ready_o rises 33 edges after start; result_o = {0x00000002, 0x0000000E}; ready drops the edge after start drops.
2. Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Unsigned 0xFFFFFFFF / 0x00000001 -> quotient 0xFFFFFFFF, remainder 0. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
4. Divisor 0 with dividend 0x12345678 -> ready_o high after 2 edges; result_o = 0.
5. annul_i pulsed at cycle 10 of ON -> FREE next edge, ready_o never asserts. Then a fresh 9 / 3 -> result {0, 3} after 33 edges.
6. rst asserted at cycle 15 of ON -> state FREE, outputs 0. Operands changed mid-ON (no rst) -> result matches the originally latched operands.
